// File: rtl/pair_match_checker.sv
// Purpose: latches a target switch map on start and judges each raised switch as hit or miss until win/lose.
// Latency: a switch edge sampled on cycle t gives a registered hit/miss pulse during cycle t+1; state flags update on the same edge.
// Backpressure: none; simultaneous raises queue internally and are judged lowest index first, one per cycle.
module pair_match_checker #(
    parameter int N_SW     = 15,
    parameter int MAX_MISS = 3,
    parameter int MISS_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_SW-1:0]   target,
    input  logic [N_SW-1:0]   sw,
    output logic [N_SW-1:0]   matched,
    output logic [MISS_W-1:0] miss_cnt,
    output logic              hit,
    output logic              miss,
    output logic              busy,
    output logic              done,
    output logic              win
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_PLAY = 3'd2,
        S_WIN  = 3'd3,
        S_LOSE = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [N_SW-1:0]   tgt;
    logic [N_SW-1:0]   seen;
    logic [N_SW-1:0]   seen_kept;
    logic [N_SW-1:0]   pending;
    logic [N_SW-1:0]   pick;
    logic              pick_vld;
    logic              pick_hit;
    logic              all_found;
    logic              last_miss;
    logic              busy_nxt;
    logic              done_nxt;
    logic              win_nxt;

    // Guess judging: lowered switches re-arm, then the lowest fresh, unmatched raise is picked.
    always_comb begin
        seen_kept = seen & sw;
        pending   = sw & ~seen_kept & ~matched;
        pick      = pending & (~pending + N_SW'(1));
        pick_vld  = |pending;
        pick_hit  = |(pick & tgt);
        all_found = ((matched | (pick & tgt)) == tgt);
        last_miss = ((miss_cnt + MISS_W'(1)) == MISS_W'(MAX_MISS));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the single judged guess alone decides win or loss, so a hit never loses.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_nxt = (target == '0) ? S_WIN : S_ARM;
                end
            end
            S_ARM: begin
                if (sw == '0) begin
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (pick_vld) begin
                    if (pick_hit && all_found) begin
                        state_nxt = S_WIN;
                    end else if (!pick_hit && last_miss) begin
                        state_nxt = S_LOSE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Round datapath: target latch, re-arm tracking, match map, miss counter and guess pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt      <= '0;
            seen     <= '0;
            matched  <= '0;
            miss_cnt <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            unique case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        tgt      <= target;
                        seen     <= '0;
                        matched  <= '0;
                        miss_cnt <= '0;
                    end
                end
                S_PLAY: begin
                    seen <= seen_kept | pick;
                    if (pick_vld) begin
                        if (pick_hit) begin
                            matched <= matched | pick;
                            hit     <= 1'b1;
                        end else begin
                            miss_cnt <= miss_cnt + MISS_W'(1);
                            miss     <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags decoded from the next state so they are registered alongside it.
    always_comb begin
        busy_nxt = (state_nxt == S_ARM) || (state_nxt == S_PLAY);
        done_nxt = (state_nxt == S_WIN) || (state_nxt == S_LOSE);
        win_nxt  = (state_nxt == S_WIN);
    end

    // Status flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            win  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            win  <= win_nxt;
        end
    end

endmodule

// File: tb/tb_pair_match_checker.sv
// Purpose: directed self-checking bench for pair_match_checker.
// Latency: outputs are sampled 1 ns after each rising edge; inputs change at the same point.
// Backpressure: not applicable; stimulus is fully directed.
module tb_pair_match_checker;

    localparam int N_SW   = 15;
    localparam int MISS_W = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [N_SW-1:0]   target;
    logic [N_SW-1:0]   sw;
    logic [N_SW-1:0]   matched;
    logic [MISS_W-1:0] miss_cnt;
    logic              hit;
    logic              miss;
    logic              busy;
    logic              done;
    logic              win;

    int total;
    int bad;
    int hits;
    int misses;

    pair_match_checker #(
        .N_SW    (N_SW),
        .MAX_MISS(3),
        .MISS_W  (MISS_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .target  (target),
        .sw      (sw),
        .matched (matched),
        .miss_cnt(miss_cnt),
        .hit     (hit),
        .miss    (miss),
        .busy    (busy),
        .done    (done),
        .win     (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock, then sample; counts pulses and checks hit/miss exclusivity every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (hit === 1'b1) hits++;
        if (miss === 1'b1) misses++;
        check("hit_miss_excl", {31'd0, hit & miss}, 32'd0);
    endtask

    task automatic begin_round(input logic [N_SW-1:0] t);
        target = t;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        hits   = 0;
        misses = 0;
        rst    = 1'b0;
        start  = 1'b0;
        target = '0;
        sw     = '0;

        // Reset state
        tick();
        tick();
        check("rst_matched", {17'd0, matched}, 32'd0);
        check("rst_miss_cnt", {28'd0, miss_cnt}, 32'd0);
        check("rst_flags", {27'd0, hit, miss, busy, done, win}, 32'd0);
        rst = 1'b1;
        tick();
        check("idle_flags", {27'd0, hit, miss, busy, done, win}, 32'd0);

        // T2: win with three single-switch hits
        begin_round(15'h0421);
        check("t2_busy_arm", {31'd0, busy}, 32'd1);
        tick();
        hits = 0; misses = 0;
        sw = 15'h0001; tick();
        check("t2_hit0", {31'd0, hit}, 32'd1);
        sw = 15'h0021; tick();
        check("t2_hit5", {31'd0, hit}, 32'd1);
        sw = 15'h0421; tick();
        check("t2_matched", {17'd0, matched}, 32'h0421);
        tick();
        check("t2_win_done", {30'd0, win, done}, 32'd3);
        check("t2_busy", {31'd0, busy}, 32'd0);
        check("t2_miss_cnt", {28'd0, miss_cnt}, 32'd0);
        check("t2_hits", hits, 32'd3);
        check("t2_misses", misses, 32'd0);

        // T1: asynchronous reset mid-round with matched=0x0003
        sw = '0;
        begin_round(15'h0007);
        tick();
        sw = 15'h0001; tick();
        sw = 15'h0003; tick();
        check("t1_pre_matched", {17'd0, matched}, 32'h0003);
        check("t1_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t1_matched", {17'd0, matched}, 32'd0);
        check("t1_flags", {27'd0, hit, miss, busy, done, win}, 32'd0);
        sw = '0;
        tick();
        rst = 1'b1;

        // T3: three misses lose the round
        begin_round(15'h0001);
        tick();
        hits = 0; misses = 0;
        sw = 15'h0002; tick();
        check("t3_miss1", {31'd0, miss}, 32'd1);
        check("t3_cnt1", {28'd0, miss_cnt}, 32'd1);
        sw = 15'h0006; tick();
        sw = 15'h000E; tick();
        tick();
        check("t3_done_win", {30'd0, win, done}, 32'd1);
        check("t3_matched", {17'd0, matched}, 32'd0);
        check("t3_miss_cnt", {28'd0, miss_cnt}, 32'd3);
        check("t3_misses", misses, 32'd3);
        sw = 15'h000F; tick();
        sw = 15'h0000; tick();
        sw = 15'h000F; tick();
        check("t3_frozen_cnt", {28'd0, miss_cnt}, 32'd3);
        check("t3_frozen_matched", {17'd0, matched}, 32'd0);
        check("t3_frozen_pulses", hits + misses, 32'd3);

        // T6: restart from LOSE with a raised switch lands in ARM
        begin_round(15'h4000);
        check("t6_lose_restart_busy", {30'd0, busy, done}, 32'd2);
        check("t6_lose_restart_cnt", {28'd0, miss_cnt}, 32'd0);
        check("t6_lose_restart_matched", {17'd0, matched}, 32'd0);

        // T4: simultaneous raise judged one bit per cycle
        rst = 1'b0; sw = '0; tick(); rst = 1'b1;
        begin_round(15'h0006);
        tick();
        sw = 15'h0007; tick();
        check("t4_c1_hm", {30'd0, hit, miss}, 32'd1);
        check("t4_c1_cnt", {28'd0, miss_cnt}, 32'd1);
        tick();
        check("t4_c2_hm", {30'd0, hit, miss}, 32'd2);
        check("t4_c2_matched", {17'd0, matched}, 32'h0002);
        tick();
        check("t4_c3_hm", {30'd0, hit, miss}, 32'd2);
        check("t4_c3_matched", {17'd0, matched}, 32'h0006);
        tick();
        check("t4_win", {30'd0, win, done}, 32'd3);
        check("t4_miss_cnt", {28'd0, miss_cnt}, 32'd1);

        // T5: pre-raised switch holds ARM; re-arming via lower/raise
        sw = 15'h0001;
        begin_round(15'h0002);
        hits = 0; misses = 0;
        tick(); tick(); tick();
        check("t5_arm_hold", misses + hits, 32'd0);
        check("t5_arm_busy", {31'd0, busy}, 32'd1);
        sw = '0; tick();
        sw = 15'h0001; tick();
        sw = 15'h0000; tick();
        sw = 15'h0001; tick();
        sw = 15'h0000; tick();
        check("t5_misses", misses, 32'd2);
        check("t5_miss_cnt", {28'd0, miss_cnt}, 32'd2);
        sw = 15'h0002; tick();
        sw = 15'h0000; tick();
        sw = 15'h0002; tick();
        check("t5_hits", hits, 32'd1);
        check("t5_win", {31'd0, win}, 32'd1);

        // T6: empty target wins immediately
        sw = '0;
        begin_round(15'h0000);
        check("t6_zero_win", {29'd0, busy, done, win}, 32'd3);

        // T6: start during PLAY is ignored
        begin_round(15'h0003);
        tick();
        sw = 15'h0001; tick();
        target = 15'h0000;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("t6_play_start_matched", {17'd0, matched}, 32'h0001);
        check("t6_play_start_flags", {29'd0, busy, done, win}, 32'd4);
        sw = 15'h0003; tick();
        tick();
        check("t6_play_finish", {17'd0, matched}, 32'h0003);
        check("t6_play_win", {31'd0, win}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
